// File: rtl/disp_sched_pkg.sv
// disp_sched shared types: owner states, source IDs, digit width.
// Imported by disp_sched and disp_upd_guard.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    S_TEMP = 2'd0,
    S_SET  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_TEMP = 2'd0;
  localparam logic [1:0] SRC_SET  = 2'd1;
  localparam logic [1:0] SRC_ERR  = 2'd2;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/disp_upd_guard.sv
// disp_upd_guard: paces digit updates so the driver's latch window
// always sees stable data; holds one pending (latest-wins) request.
module disp_upd_guard
  import disp_sched_pkg::*;
#(
  parameter int DIGIT_NUM = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic                         req_full,
  input  logic [DIGIT_NUM*DIGIT_W-1:0] req_data,
  output logic [DIGIT_NUM*DIGIT_W-1:0] dout,
  output logic [DIGIT_NUM-1:0]         dout_vld
);

  localparam int DW = DIGIT_NUM * DIGIT_W;
  localparam int CW = $clog2(DIGIT_NUM + 1);

  logic [CW-1:0]        cnt;
  logic                 busy;
  logic                 pend;
  logic                 pend_full;
  logic [DW-1:0]        pend_data;
  logic [DW-1:0]        iss_data;
  logic                 iss_full;
  logic [DIGIT_NUM-1:0] diff;
  logic [DIGIT_NUM-1:0] mask;
  logic                 fire;

  assign busy = (cnt != '0);

  // dout doubles as the last-issued register for the delta mask
  always_comb begin
    iss_data = req ? req_data : pend_data;
    iss_full = (req & req_full) | (pend & pend_full);
    diff     = '0;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      diff[i] = iss_data[i*DIGIT_W +: DIGIT_W]
             != dout[i*DIGIT_W +: DIGIT_W];
    end
    mask = iss_full ? '1 : diff;
    fire = !busy && (req || pend) && (mask != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dout      <= '0;
      dout_vld  <= '0;
      pend      <= 1'b0;
      pend_full <= 1'b0;
      pend_data <= '0;
    end else begin
      dout_vld <= '0;
      if (fire) begin
        dout     <= iss_data;
        dout_vld <= mask;
        cnt      <= CW'(DIGIT_NUM);
      end else if (busy) begin
        cnt <= cnt - 1'b1;
      end
      if (busy) begin
        if (req) begin
          pend      <= 1'b1;
          pend_data <= req_data;
          pend_full <= pend_full | req_full;
        end
      end else begin
        pend      <= 1'b0;
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/disp_sched.sv
// disp_sched: display owner arbitration (temp/set/err) with hold timeout.
// Optional error blink when DISP_BLINK_EN is defined.
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int DIGIT_NUM = 4,
  parameter int HOLD_CNT  = 150_000_000,
  parameter int BLINK_CNT = 12_500_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIGIT_NUM*DIGIT_W-1:0] temp_din,
  input  logic                         temp_vld,
  input  logic [DIGIT_NUM*DIGIT_W-1:0] set_din,
  input  logic                         set_vld,
  input  logic [DIGIT_NUM*DIGIT_W-1:0] err_din,
  input  logic                         err_vld,
  input  logic                         err_clr,
  output logic [DIGIT_NUM*DIGIT_W-1:0] dout,
  output logic [DIGIT_NUM-1:0]         dout_vld,
  output logic                         disp_en,
  output logic [1:0]                   cur_src
);

  localparam int DW = DIGIT_NUM * DIGIT_W;
  localparam int HW = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT - 1);

  state_t        state, state_nxt;
  logic [HW-1:0] hold;
  logic [DW-1:0] t_shd, s_shd, e_shd;
  logic [DW-1:0] t_nxt, s_nxt, e_nxt;
  logic          boot;
  logic          own_vld;
  logic          chg;
  logic          req;
  logic          req_full;
  logic [DW-1:0] req_data;

  always_comb begin
    t_nxt     = temp_vld ? temp_din : t_shd;
    s_nxt     = set_vld  ? set_din  : s_shd;
    e_nxt     = err_vld  ? err_din  : e_shd;
    state_nxt = state;
    own_vld   = 1'b0;
    case (state)
      S_TEMP: begin
        own_vld = temp_vld;
        if (err_vld)      state_nxt = S_ERR;
        else if (set_vld) state_nxt = S_SET;
      end
      S_SET: begin
        own_vld = set_vld;
        if (err_vld)
          state_nxt = S_ERR;
        else if (!set_vld && hold == HOLD_MAX)
          state_nxt = S_TEMP;
      end
      S_ERR: begin
        own_vld = err_vld;
        if (err_clr && !err_vld) state_nxt = S_TEMP;
      end
      default: state_nxt = S_TEMP;
    endcase
    case (state_nxt)
      S_SET:   req_data = s_nxt;
      S_ERR:   req_data = e_nxt;
      default: req_data = t_nxt;
    endcase
    chg      = (state_nxt != state);
    req_full = boot | chg;
    req      = req_full | own_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_TEMP;
      hold  <= HOLD_MAX;
      t_shd <= '0;
      s_shd <= '0;
      e_shd <= '0;
      boot  <= 1'b1;
    end else begin
      state <= state_nxt;
      t_shd <= t_nxt;
      s_shd <= s_nxt;
      e_shd <= e_nxt;
      boot  <= 1'b0;
      if (state_nxt == S_SET && (state != S_SET || set_vld))
        hold <= '0;
      else if (hold != HOLD_MAX)
        hold <= hold + 1'b1;
    end
  end

  always_comb begin
    case (state)
      S_SET:   cur_src = SRC_SET;
      S_ERR:   cur_src = SRC_ERR;
      default: cur_src = SRC_TEMP;
    endcase
  end

`ifdef DISP_BLINK_EN
  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      disp_en   <= 1'b0;
    end else if (state_nxt == S_ERR && state != S_ERR) begin
      blink_cnt <= '0;
      disp_en   <= 1'b1;
    end else if (state_nxt == S_ERR) begin
      if (blink_cnt == BW'(BLINK_CNT - 1)) begin
        blink_cnt <= '0;
        disp_en   <= ~disp_en;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      disp_en <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_en <= 1'b0;
    else        disp_en <= 1'b1;
  end
`endif

  disp_upd_guard #(
    .DIGIT_NUM (DIGIT_NUM)
  ) u_guard (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_full (req_full),
    .req_data (req_data),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: directed vector table, blink/reset sequences and
// randomized traffic checked against a timestamp-based reference model.
module tb_disp_sched;

  localparam int DN = 4;
  localparam int HC = 20;
  localparam int BC = 8;
`ifdef DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] temp_din, set_din, err_din;
  logic        temp_vld, set_vld, err_vld, err_clr;
  logic [15:0] dout;
  logic [3:0]  dout_vld;
  logic        disp_en;
  logic [1:0]  cur_src;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  disp_sched #(
    .DIGIT_NUM (DN),
    .HOLD_CNT  (HC),
    .BLINK_CNT (BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .temp_din (temp_din),
    .temp_vld (temp_vld),
    .set_din  (set_din),
    .set_vld  (set_vld),
    .err_din  (err_din),
    .err_vld  (err_vld),
    .err_clr  (err_clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .disp_en  (disp_en),
    .cur_src  (cur_src)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner by priority rules, timers as timestamps
  int          k, m_own, m_hs, m_bs, m_lp;
  logic [15:0] m_sh [3];
  logic [15:0] m_dout, m_pdata;
  logic [3:0]  m_vld;
  logic        m_en;
  bit          m_boot, m_pend, m_pfull;

  function automatic logic [3:0] nib_diff(input logic [15:0] a,
                                          input logic [15:0] b);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (a[i*4 +: 4] != b[i*4 +: 4]);
    return m;
  endfunction

  task automatic model_reset();
    k = 0; m_own = 0; m_hs = 0; m_bs = 0; m_lp = -100;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;
    m_dout = '0; m_vld = '0; m_en = 1'b0; m_pdata = '0;
    m_boot = 1; m_pend = 0; m_pfull = 0;
  endtask

  task automatic model_step();
    int nw;
    bit own_v, full, has;
    logic [15:0] data;
    logic [3:0] mask;
    nw = m_own;
    case (m_own)
      0: if (err_vld) nw = 2; else if (set_vld) nw = 1;
      1: if (err_vld) nw = 2;
         else if (!set_vld && k - m_hs >= HC - 1) nw = 0;
      default: if (err_clr && !err_vld) nw = 0;
    endcase
    own_v = (m_own == 0 && temp_vld) || (m_own == 1 && set_vld) ||
            (m_own == 2 && err_vld);
    if (nw == 1 && (m_own != 1 || set_vld)) m_hs = k + 1;
    if (nw == 2 && m_own != 2) m_bs = k + 1;
    if (temp_vld) m_sh[0] = temp_din;
    if (set_vld)  m_sh[1] = set_din;
    if (err_vld)  m_sh[2] = err_din;
    full = m_boot || (nw != m_own);
    has  = full || own_v;
    data = m_sh[nw];
    if (m_pend) begin
      full = full || m_pfull;
      if (!has) data = m_pdata;
      has = 1;
    end
    m_vld = '0;
    if (has) begin
      if (k + 1 - m_lp >= DN + 1) begin
        mask = full ? 4'hF : nib_diff(data, m_dout);
        if (mask != 0) begin
          m_dout = data; m_vld = mask; m_lp = k + 1;
        end
        m_pend = 0; m_pfull = 0;
      end else begin
        m_pend = 1; m_pfull = full; m_pdata = data;
      end
    end
    m_en = (BLINK && nw == 2) ? (((k + 1 - m_bs) / BC) % 2 == 0) : 1'b1;
    m_own = nw; m_boot = 0; k++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    if (rst_n) begin
      chk("model_dout", dout, m_dout);
      chk("model_vld", dout_vld, m_vld);
      chk("model_src", cur_src, m_own);
      chk("model_en", disp_en, m_en);
    end
    temp_vld = 0; set_vld = 0; err_vld = 0; err_clr = 0;
  endtask

  typedef struct {
    logic        tv;
    logic [15:0] td;
    logic        sv;
    logic [15:0] sd;
    logic        ev;
    logic [15:0] ed;
    logic        ec;
    int          rep;
    logic [15:0] x_dout;
    logic [3:0]  x_vld;
    logic [1:0]  x_src;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [15:0] rnd_digits();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 2));
    return v;
  endfunction

  initial begin
    tbl = '{
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0000, 4'hF, 2'd0},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 4,  16'h0000, 4'h0, 2'd0},
      '{1, 16'h0253, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0253, 4'h7, 2'd0},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 4,  16'h0253, 4'h0, 2'd0},
      '{1, 16'h0253, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0253, 4'h0, 2'd0},
      '{0, 16'h0000, 1, 16'h0300, 0, 16'h0000, 0, 1,  16'h0300, 4'hF, 2'd1},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 19, 16'h0300, 4'h0, 2'd1},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0253, 4'hF, 2'd0},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 4,  16'h0253, 4'h0, 2'd0},
      '{0, 16'h0000, 1, 16'h0400, 1, 16'h00E1, 0, 1,  16'h00E1, 4'hF, 2'd2},
      '{1, 16'h0261, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h00E1, 4'h0, 2'd2},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 3,  16'h00E1, 4'h0, 2'd2},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1,  16'h0261, 4'hF, 2'd0},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 4,  16'h0261, 4'h0, 2'd0},
      '{1, 16'h0250, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0250, 4'h3, 2'd0},
      '{1, 16'h0251, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0250, 4'h0, 2'd0},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 3,  16'h0250, 4'h0, 2'd0},
      '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1,  16'h0251, 4'h1, 2'd0}
    };

    rst_n = 0;
    temp_din = '0; set_din = '0; err_din = '0;
    temp_vld = 0; set_vld = 0; err_vld = 0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 16'h0);
    chk("rst_vld", dout_vld, 4'h0);
    chk("rst_en", disp_en, 1'b0);
    chk("rst_src", cur_src, 2'd0);
    rst_n = 1;

    foreach (tbl[r]) begin
      for (int j = 0; j < tbl[r].rep; j++) begin
        temp_vld = tbl[r].tv; temp_din = tbl[r].td;
        set_vld  = tbl[r].sv; set_din  = tbl[r].sd;
        err_vld  = tbl[r].ev; err_din  = tbl[r].ed;
        err_clr  = tbl[r].ec;
        tick();
        chk($sformatf("vec%0d_dout", r), dout, tbl[r].x_dout);
        chk($sformatf("vec%0d_vld", r), dout_vld, tbl[r].x_vld);
        chk($sformatf("vec%0d_src", r), cur_src, tbl[r].x_src);
        chk($sformatf("vec%0d_en", r), disp_en, 1'b1);
      end
    end

    // error blink pattern from entry, then exit
    err_vld = 1; err_din = 16'h00E2;
    tick();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("blink%0d", i), disp_en,
          BLINK ? 32'(((i / BC) % 2) == 0) : 32'd1);
      tick();
    end
    err_clr = 1;
    tick();
    chk("blink_exit_en", disp_en, 1'b1);
    chk("blink_exit_src", cur_src, 2'd0);

    // asynchronous reset in the middle of a set view
    set_vld = 1; set_din = 16'h0777;
    tick();
    tick();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_dout", dout, 16'h0);
    chk("mid_rst_vld", dout_vld, 4'h0);
    chk("mid_rst_en", disp_en, 1'b0);
    chk("mid_rst_src", cur_src, 2'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    chk("reboot_vld", dout_vld, 4'hF);
    chk("reboot_dout", dout, 16'h0);

    for (int n = 0; n < 3000; n++) begin
      temp_vld = ($urandom_range(0, 9) < 3);
      temp_din = rnd_digits();
      set_vld  = ($urandom_range(0, 99) < 4);
      set_din  = rnd_digits();
      err_vld  = ($urandom_range(0, 99) < 2);
      err_din  = rnd_digits();
      err_clr  = ($urandom_range(0, 99) < 6);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
